// File: rtl/ddr2_line_responder.sv
`default_nettype none
// ============================================================================
// Module   : ddr2_line_responder
// Purpose  : DDR2-style 128-bit line responder over a 32-bit word RAM.
// Revision : 1.0 - initial release
// ============================================================================
module ddr2_line_responder #(
    parameter int LINE_BITS = 10,
    parameter int LATENCY   = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ddr2_enable,
    input  logic         ddr2_read,
    input  logic [26:0]  ddr2_addr,
    input  logic [127:0] to_ddr2_data,
    output logic [127:0] ddr2_data,
    output logic         ddr2_available,
    output logic         busy,
    output logic         overflow
);

    localparam int         AW    = LINE_BITS + 2;
    localparam logic [3:0] C_LAT = 4'(LATENCY);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WAIT = 3'd1,
        S_WR   = 3'd2,
        S_RD   = 3'd3,
        S_RCAP = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t                 r_state;
    logic [3:0]             r_cnt;
    logic [1:0]             r_beat;
    logic [LINE_BITS-1:0]   r_act_line;
    logic                   r_act_read;
    logic [127:0]           r_act_data;
    logic                   r_pend_valid;
    logic [LINE_BITS-1:0]   r_pend_line;
    logic                   r_pend_read;
    logic [127:0]           r_pend_data;
    logic [127:0]           r_line;
    logic [31:0]            r_mem [0:(1<<AW)-1];
    logic [31:0]            r_rdata;

    logic [LINE_BITS-1:0]   w_req_line;
    logic [AW-1:0]          w_word_addr;
    logic                   w_wr_en;
    logic [31:0]            w_wr_word;
    logic                   w_unused;

    assign w_req_line  = ddr2_addr[LINE_BITS+3:4];
    assign w_word_addr = {r_act_line, r_beat};
    assign w_wr_en     = (r_state == S_WR);
    assign w_wr_word   = r_act_data[{r_beat, 5'd0} +: 32];
    assign w_unused    = ^{ddr2_addr[26:LINE_BITS+4], ddr2_addr[3:0]};
    assign busy        = (r_state != S_IDLE) || r_pend_valid;

    // Word RAM is deliberately left unreset; contents survive rst_n.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[w_word_addr] <= w_wr_word;
        end
        r_rdata <= r_mem[w_word_addr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_cnt          <= 4'd0;
            r_beat         <= 2'd0;
            r_act_line     <= '0;
            r_act_read     <= 1'b0;
            r_act_data     <= '0;
            r_pend_valid   <= 1'b0;
            r_pend_line    <= '0;
            r_pend_read    <= 1'b0;
            r_pend_data    <= '0;
            r_line         <= '0;
            ddr2_data      <= '0;
            ddr2_available <= 1'b0;
            overflow       <= 1'b0;
        end else begin
            ddr2_available <= 1'b0;

            // Requests arriving while the engine is occupied go to the slot.
            if (ddr2_enable && (r_state != S_IDLE)) begin
                if (!r_pend_valid) begin
                    r_pend_valid <= 1'b1;
                    r_pend_line  <= w_req_line;
                    r_pend_read  <= ddr2_read;
                    r_pend_data  <= to_ddr2_data;
                end else begin
                    overflow <= 1'b1;
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (r_pend_valid) begin
                        r_act_line <= r_pend_line;
                        r_act_read <= r_pend_read;
                        r_act_data <= r_pend_data;
                        r_cnt      <= C_LAT;
                        r_state    <= S_WAIT;
                        if (ddr2_enable) begin
                            r_pend_line <= w_req_line;
                            r_pend_read <= ddr2_read;
                            r_pend_data <= to_ddr2_data;
                        end else begin
                            r_pend_valid <= 1'b0;
                        end
                    end else if (ddr2_enable) begin
                        r_act_line <= w_req_line;
                        r_act_read <= ddr2_read;
                        r_act_data <= to_ddr2_data;
                        r_cnt      <= C_LAT;
                        r_state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_beat  <= 2'd0;
                        r_state <= r_act_read ? S_RD : S_WR;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_WR: begin
                    r_beat <= r_beat + 2'd1;
                    if (r_beat == 2'd3) begin
                        r_state <= S_DONE;
                    end
                end
                S_RD: begin
                    // r_rdata holds the beat issued on the previous cycle.
                    if (r_beat != 2'd0) begin
                        r_line[{r_beat - 2'd1, 5'd0} +: 32] <= r_rdata;
                    end
                    r_beat <= r_beat + 2'd1;
                    if (r_beat == 2'd3) begin
                        r_state <= S_RCAP;
                    end
                end
                S_RCAP: begin
                    r_line[127:96] <= r_rdata;
                    r_state        <= S_DONE;
                end
                S_DONE: begin
                    if (r_act_read) begin
                        ddr2_data      <= r_line;
                        ddr2_available <= 1'b1;
                    end
                    if (r_pend_valid) begin
                        r_act_line   <= r_pend_line;
                        r_act_read   <= r_pend_read;
                        r_act_data   <= r_pend_data;
                        r_pend_valid <= 1'b0;
                        r_cnt        <= C_LAT;
                        r_state      <= S_WAIT;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ddr2_line_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_ddr2_line_responder
// Purpose  : Scoreboard bench for ddr2_line_responder (LATENCY=4 and 0 builds).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ddr2_line_responder;

    localparam int L  = 4;
    localparam int LB = 10;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         ddr2_enable, ddr2_read;
    logic [26:0]  ddr2_addr;
    logic [127:0] to_ddr2_data, ddr2_data;
    logic         ddr2_available, busy, overflow;

    logic         e1, r1;
    logic [26:0]  a1;
    logic [127:0] d1, q1data;
    logic         q1av, q1busy, q1ovf;

    typedef struct {
        logic [127:0] d;
        int           c;
    } exp_t;

    exp_t         q[$];
    logic [127:0] model [int];
    int           cyc = 0;
    int           n_vec = 0;
    int           n_err = 0;
    int           n_pulse = 0;
    logic [127:0] prev_data = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ddr2_line_responder #(.LINE_BITS(LB), .LATENCY(L)) u_dut (
        .clk(clk), .rst_n(rst_n), .ddr2_enable(ddr2_enable), .ddr2_read(ddr2_read),
        .ddr2_addr(ddr2_addr), .to_ddr2_data(to_ddr2_data), .ddr2_data(ddr2_data),
        .ddr2_available(ddr2_available), .busy(busy), .overflow(overflow)
    );

    ddr2_line_responder #(.LINE_BITS(LB), .LATENCY(0)) u_dut_l0 (
        .clk(clk), .rst_n(rst_n), .ddr2_enable(e1), .ddr2_read(r1),
        .ddr2_addr(a1), .to_ddr2_data(d1), .ddr2_data(q1data),
        .ddr2_available(q1av), .busy(q1busy), .overflow(q1ovf)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    // Read completions are popped from the scoreboard as they appear.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_data = ddr2_data;
        end else if (ddr2_available) begin
            n_pulse++;
            if (q.size() == 0) begin
                chk("spurious_pulse", {127'd0, ddr2_available}, 128'd0);
            end else begin
                e = q.pop_front();
                chk("rdata", ddr2_data, e.d);
                if (e.c >= 0) chk("latency", 128'(cyc), 128'(e.c));
            end
            prev_data = ddr2_data;
        end else begin
            chk("data_hold", ddr2_data, prev_data);
        end
    end

    task automatic send(input logic rd, input logic [26:0] addr, input logic [127:0] data,
                        input bit drop, input bit timed);
        exp_t e;
        @(negedge clk);
        ddr2_enable  = 1'b1;
        ddr2_read    = rd;
        ddr2_addr    = addr;
        to_ddr2_data = data;
        if (!drop) begin
            if (rd) begin
                e.d = model[int'(addr[LB+3:4])];
                e.c = timed ? cyc + L + 8 : -1;
                q.push_back(e);
            end else begin
                model[int'(addr[LB+3:4])] = data;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            ddr2_enable = 1'b0;
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            ddr2_enable = 1'b0;
            if (!busy && q.size() == 0) break;
        end
        chk("idle_timeout", {127'd0, busy}, 128'd0);
        chk("sb_empty", 128'(q.size()), 128'd0);
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic [127:0] d_a, d_b;
        logic [26:0]  ad;
        int           p0, k;

        rst_n = 1'b0; ddr2_enable = 1'b0; ddr2_read = 1'b0; ddr2_addr = '0; to_ddr2_data = '0;
        e1 = 1'b0; r1 = 1'b0; a1 = '0; d1 = '0;
        #1;
        chk("rst_busy", {127'd0, busy}, 128'd0);
        chk("rst_avail", {127'd0, ddr2_available}, 128'd0);
        chk("rst_ovf", {127'd0, overflow}, 128'd0);
        chk("rst_data", ddr2_data, 128'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Basic write/read at 0x40 with timing, then aliased read.
        d_a = 128'h0000_0004_0000_0003_0000_0002_0000_0001;
        send(1'b0, 27'h40, d_a, 1'b0, 1'b0);
        wait_idle();
        p0 = n_pulse;
        send(1'b1, 27'h40, '0, 1'b0, 1'b1);
        wait_idle();
        chk("one_pulse", 128'(n_pulse - p0), 128'd1);
        send(1'b1, 27'h40 + (27'd1 << (LB + 4)), '0, 1'b0, 1'b1);
        wait_idle();

        // Random lines, read back through an aliased address.
        for (int i = 0; i < 6; i++) begin
            ad = 27'($urandom);
            send(1'b0, ad, rnd128(), 1'b0, 1'b0);
            wait_idle();
            send(1'b1, ad ^ (27'd1 << 20), '0, 1'b0, 1'b1);
            wait_idle();
        end

        // Write then read on consecutive cycles.
        p0 = n_pulse;
        send(1'b0, 27'h1230, rnd128(), 1'b0, 1'b0);
        send(1'b1, 27'h1230, '0, 1'b0, 1'b0);
        idle(1);
        wait_idle();
        chk("b2b_pulse", 128'(n_pulse - p0), 128'd1);
        chk("b2b_ovf", {127'd0, overflow}, 128'd0);

        // Request arriving during DONE of a write.
        send(1'b0, 27'h2340, rnd128(), 1'b0, 1'b0);
        k = cyc;
        idle(L + 5);
        chk("done_slot_cycle", 128'(cyc), 128'(k + L + 5));
        send(1'b1, 27'h2340, '0, 1'b0, 1'b0);
        idle(1);
        wait_idle();

        // Three requests on consecutive cycles: third is dropped.
        d_b = rnd128();
        send(1'b0, 27'h3450, d_b, 1'b0, 1'b0);
        wait_idle();
        p0 = n_pulse;
        send(1'b0, 27'h4560, rnd128(), 1'b0, 1'b0);
        send(1'b1, 27'h4560, '0, 1'b0, 1'b0);
        send(1'b0, 27'h3450, rnd128(), 1'b1, 1'b0);
        idle(1);
        wait_idle();
        chk("drop_ovf", {127'd0, overflow}, 128'd1);
        chk("drop_pulse", 128'(n_pulse - p0), 128'd1);
        send(1'b1, 27'h3450, '0, 1'b0, 1'b1);
        idle(1);
        wait_idle();
        chk("ovf_sticky", {127'd0, overflow}, 128'd1);

        // LATENCY=0 build.
        @(negedge clk); e1 = 1'b1; r1 = 1'b0; a1 = 27'h80; d1 = 128'hA5A5_0123_4567_89AB_CDEF_F00D_BEEF_5A5A;
        @(negedge clk); e1 = 1'b0;
        repeat (12) @(negedge clk);
        @(negedge clk); e1 = 1'b1; r1 = 1'b1; k = cyc;
        @(negedge clk); e1 = 1'b0;
        for (int i = 0; i < 30 && !q1av; i++) @(negedge clk);
        chk("l0_avail", {127'd0, q1av}, 128'd1);
        chk("l0_latency", 128'(cyc), 128'(k + 8));
        chk("l0_data", q1data, 128'hA5A5_0123_4567_89AB_CDEF_F00D_BEEF_5A5A);
        @(negedge clk);
        chk("l0_busy_after", {127'd0, q1busy}, 128'd0);
        chk("l0_pulse_width", {127'd0, q1av}, 128'd0);

        // Reset during RD aborts silently.
        send(1'b1, 27'h40, '0, 1'b0, 1'b1);
        k = cyc;
        idle(L + 3);
        #1 rst_n = 1'b0;
        #1;
        q.delete();
        chk("abort_busy", {127'd0, busy}, 128'd0);
        chk("abort_ovf", {127'd0, overflow}, 128'd0);
        chk("abort_avail", {127'd0, ddr2_available}, 128'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        p0 = n_pulse;
        idle(15);
        chk("abort_no_pulse", 128'(n_pulse - p0), 128'd0);
        send(1'b0, 27'h5670, rnd128(), 1'b0, 1'b0);
        wait_idle();
        send(1'b1, 27'h5670, '0, 1'b0, 1'b1);
        wait_idle();
        chk("post_rst_pulse", 128'(n_pulse - p0), 128'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ddr2_line_responder.md
DDR2_LINE_RESPONDER -- requirements
Module: ddr2_line_responder

Interface
REQ-001 SHALL have parameter LINE_BITS, default 10, meaning the number of line-index bits, giving 2^LINE_BITS lines of 128 bits each.
REQ-002 SHALL have parameter LATENCY, default 4, meaning the extra wait cycles before the beats; legal range 0-15.
REQ-003 SHALL have one clock and an asynchronous active-low reset: clk, in, 1 bit; rst_n, in, 1 bit.
REQ-004 SHALL have ports:
- ddr2_enable, in, 1 bit: request strobe; each cycle it is high is one request.
- ddr2_read, in, 1 bit: 1 = read line, 0 = write line; sampled with ddr2_enable.
- ddr2_addr, in, 27 bits: byte address; bits [3:0] ignored.
- to_ddr2_data, in, 128 bits: write line; sampled with ddr2_enable.
- ddr2_data, out, 128 bits: read line.
- ddr2_available, out, 1 bit: one-cycle read-completion pulse.
- busy, out, 1 bit: FSM not IDLE, or the pending slot is occupied.
- overflow, out, 1 bit: sticky flag; a request was dropped.

Function
REQ-005 SHALL store lines in an internal 32-bit-wide word RAM: word address = {line, beat[1:0]}, line = ddr2_addr[LINE_BITS+3:4], higher address bits ignored (aliasing).
REQ-006 SHALL map beat k to line bits [32k+31:32k] (k = 0..3); beat 0 = word offset 0.
REQ-007 SHALL implement FSM states IDLE, WAIT, WR, RD, RCAP, DONE.
REQ-008 IDLE with ddr2_enable=1 SHALL capture addr, read and data into the active registers at that edge (edge 0):
- next state WAIT with the counter loaded to LATENCY;
- if LATENCY=0, WAIT lasts exactly 1 cycle.
REQ-009 WAIT SHALL decrement once per cycle, then enter RD (read) or WR (write).
REQ-010 WR SHALL write beats 0..3 on four consecutive cycles, then go to DONE.
REQ-011 RD SHALL issue reads of beats 0..3 on four consecutive cycles; RAM read latency is 1 cycle; RCAP captures the final beat; then DONE.
REQ-012 For a read, DONE SHALL drive ddr2_data with the full line and hold ddr2_available=1 for exactly one cycle. This is edge LATENCY+7 after edge 0 (the edge at which ddr2_available rises, counting edge 0 as the accept edge).
REQ-013 For a write, DONE SHALL produce no ddr2_available pulse; writes complete silently.
REQ-014 ddr2_data SHALL hold its value until the next read completion; it SHALL change on no other cycle.
REQ-015 Pending slot: one-deep. A request arriving while the FSM is not IDLE SHALL be captured there if the slot is empty.
REQ-016 A request arriving while the slot is full and the FSM is not IDLE SHALL be dropped and SHALL set overflow, which stays set until reset.
REQ-017 From DONE, if the slot is occupied, the FSM SHALL move the pending request into the active registers, free the slot and enter WAIT. Otherwise it SHALL return to IDLE.
REQ-018 A request in the same cycle as DONE with an empty slot SHALL be captured into the slot and serviced next, not lost.
REQ-019 Requests SHALL execute strictly in arrival order; a read after a write to the same line returns the written data.
REQ-020 Back-to-back requests on consecutive cycles (write then read) SHALL both be serviced, with no overflow.

Reset
REQ-021 rst_n=0 SHALL immediately force state IDLE, slot empty, counter 0, ddr2_available=0, ddr2_data=0, busy=0 and overflow=0.
REQ-022 Reset mid-operation SHALL abort the active and pending requests with no pulse. Beats of a write already performed MAY remain in RAM.
REQ-023 RAM contents SHALL NOT be cleared by reset; they are undefined until written.

Verification
REQ-024 Write line 0x0000_0004_0000_0003_0000_0002_0000_0001 at addr 0x40, then read addr 0x40 -> identical line; ddr2_available high exactly 1 cycle, at edge LATENCY+7 after the read accept.
REQ-025 Write at cycle t and read of the same line at t+1 (ddr2_read 0 then 1) -> read returns the written line; exactly one pulse; overflow=0.
REQ-026 Three requests on cycles t, t+1, t+2 while busy -> third dropped, overflow=1 and sticky; the first two complete in order.
REQ-027 LATENCY=0 build: read accepted at edge 0 -> ddr2_available at edge 7; busy=0 the following cycle.
REQ-028 Assert rst_n=0 during RD of a read -> no pulse, busy=0 and overflow=0 immediately. A new read after release completes normally.
REQ-029 Write at addr 0x40 then read at 0x40 + (1 << (LINE_BITS+4)) -> returns the same line (alias).
